// File: rtl/card_pkg.sv
// Shared constants, enums and template helpers for the card-corner scoring path.
package card_pkg;

  localparam int CORNER_WIDTH = 28;
  localparam int RANK_HEIGHT  = 40;
  localparam int SUIT_HEIGHT  = 29;
  localparam int ROM_LATENCY  = 2;

  localparam int RANK_SIZE = CORNER_WIDTH * RANK_HEIGHT;
  localparam int SUIT_SIZE = CORNER_WIDTH * SUIT_HEIGHT;
  localparam int RANK_W    = $clog2(RANK_SIZE);
  localparam int SUIT_W    = $clog2(SUIT_SIZE);

  localparam int NUM_RANKS = 13;
  localparam int NUM_SUITS = 4;

  localparam int SPADE_INK_FIRST = 10 * CORNER_WIDTH + 8;
  localparam int SPADE_INK_COUNT = 12;

  typedef enum logic [3:0] {
    RANK_TWO, RANK_THREE, RANK_FOUR, RANK_FIVE, RANK_SIX, RANK_SEVEN, RANK_EIGHT,
    RANK_NINE, RANK_TEN, RANK_JACK, RANK_QUEEN, RANK_KING, RANK_ACE
  } rank_e;

  typedef enum logic [1:0] {
    SUIT_DIAMOND = 2'd0,
    SUIT_HEART   = 2'd1,
    SUIT_CLUB    = 2'd2,
    SUIT_SPADE   = 2'd3
  } suit_e;

  typedef enum logic [2:0] {IDLE, RANK, SUIT, DRAIN, DONE} scorer_state_e;

  typedef struct packed {
    logic valid;
    logic pixel;
    logic is_suit;
  } pix_tag_t;

  // Calibration glyph set: the "two" rank is solid ink, the spade carries a 12-pixel bar.
  function automatic logic rank_template_bit(input logic [3:0] r, input logic [RANK_W-1:0] addr);
    return (r == RANK_TWO) && (addr < RANK_W'(RANK_SIZE));
  endfunction

  function automatic logic suit_template_bit(input logic [1:0] s, input logic [SUIT_W-1:0] addr);
    return (s == SUIT_SPADE) && (addr >= SUIT_W'(SPADE_INK_FIRST)) &&
           (addr < SUIT_W'(SPADE_INK_FIRST + SPADE_INK_COUNT));
  endfunction

endpackage

// File: rtl/card_templates.sv
// Rank/suit template ROM with a registered address and a registered output (2-cycle read).
module card_templates
  import card_pkg::*;
(
  input  logic                 clk_in,
  input  logic [RANK_W-1:0]    rank_addr,
  input  logic [SUIT_W-1:0]    suit_addr,
  output logic [NUM_RANKS-1:0] rank_bits,
  output logic [NUM_SUITS-1:0] suit_bits
);

  logic [RANK_W-1:0]    rank_addr_q;
  logic [SUIT_W-1:0]    suit_addr_q;
  logic [NUM_RANKS-1:0] rank_bits_d, rank_bits_q;
  logic [NUM_SUITS-1:0] suit_bits_d, suit_bits_q;

  always_comb begin
    rank_bits_d = '0;
    suit_bits_d = '0;
    for (int r = 0; r < NUM_RANKS; r++) rank_bits_d[r] = rank_template_bit(4'(r), rank_addr_q);
    for (int s = 0; s < NUM_SUITS; s++) suit_bits_d[s] = suit_template_bit(2'(s), suit_addr_q);
  end

  always_ff @(posedge clk_in) begin
    rank_addr_q <= rank_addr;
    suit_addr_q <= suit_addr;
    rank_bits_q <= rank_bits_d;
    suit_bits_q <= suit_bits_d;
  end

  assign rank_bits = rank_bits_q;
  assign suit_bits = suit_bits_q;

endmodule

// File: rtl/corner_scorer.sv
// Counts pixel mismatches of one card corner against all rank and suit templates.
// Optional truncated-card flag: define CORNER_SCORER_TRUNC_CHECK_EN.
module corner_scorer
  import card_pkg::*;
(
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          start_in,
  input  logic                          pixel_in,
  input  logic                          pixel_valid_in,
  output logic                          busy_out,
  output logic [NUM_RANKS*RANK_W-1:0]   rank_scores_out,
  output logic [NUM_SUITS*SUIT_W-1:0]   suit_scores_out,
  output logic                          scores_valid_out,
  output logic                          error_out
);

  localparam int DRAIN_W = $clog2(ROM_LATENCY + 1);
  localparam logic [RANK_W-1:0]  RANK_LAST  = RANK_W'(RANK_SIZE - 1);
  localparam logic [SUIT_W-1:0]  SUIT_LAST  = SUIT_W'(SUIT_SIZE - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(ROM_LATENCY - 1);

  scorer_state_e        state_q, state_d;
  logic [RANK_W-1:0]    rank_addr_q, rank_addr_d;
  logic [SUIT_W-1:0]    suit_addr_q, suit_addr_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  pix_tag_t             pipe_q [ROM_LATENCY];
  pix_tag_t             pipe_d [ROM_LATENCY];
  logic [RANK_W-1:0]    rank_cnt_q [NUM_RANKS];
  logic [RANK_W-1:0]    rank_cnt_d [NUM_RANKS];
  logic [SUIT_W-1:0]    suit_cnt_q [NUM_SUITS];
  logic [SUIT_W-1:0]    suit_cnt_d [NUM_SUITS];
  logic [NUM_RANKS-1:0] rank_bits;
  logic [NUM_SUITS-1:0] suit_bits;
  logic                 accept;
  pix_tag_t             aligned;

  card_templates u_templates (
    .clk_in    (clk_in),
    .rank_addr (rank_addr_q),
    .suit_addr (suit_addr_q),
    .rank_bits (rank_bits),
    .suit_bits (suit_bits)
  );

  // A start pulse overrides everything: flush and restart the rank pass.
  always_comb begin
    state_d     = state_q;
    rank_addr_d = rank_addr_q;
    suit_addr_d = suit_addr_q;
    drain_d     = drain_q;
    accept      = 1'b0;
    case (state_q)
      IDLE: ;
      RANK: if (pixel_valid_in) begin
        accept      = 1'b1;
        rank_addr_d = rank_addr_q + RANK_W'(1);
        if (rank_addr_q == RANK_LAST) state_d = SUIT;
      end
      SUIT: if (pixel_valid_in) begin
        accept      = 1'b1;
        suit_addr_d = suit_addr_q + SUIT_W'(1);
        if (suit_addr_q == SUIT_LAST) begin
          state_d = DRAIN;
          drain_d = '0;
        end
      end
      DRAIN: begin
        drain_d = drain_q + DRAIN_W'(1);
        if (drain_q == DRAIN_LAST) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (start_in) begin
      state_d     = RANK;
      rank_addr_d = '0;
      suit_addr_d = '0;
      drain_d     = '0;
      accept      = 1'b0;
    end
  end

  // Pixel tags trail the ROM read so each one meets its own template bits.
  always_comb begin
    pipe_d[0].valid   = accept;
    pipe_d[0].pixel   = pixel_in;
    pipe_d[0].is_suit = (state_q == SUIT);
    for (int i = 1; i < ROM_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
      if (start_in) pipe_d[i].valid = 1'b0;
    end
  end

  assign aligned = pipe_q[ROM_LATENCY-1];

  always_comb begin
    for (int r = 0; r < NUM_RANKS; r++) begin
      rank_cnt_d[r] = rank_cnt_q[r];
      if (aligned.valid && !aligned.is_suit && (aligned.pixel != rank_bits[r]))
        rank_cnt_d[r] = rank_cnt_q[r] + RANK_W'(1);
      if (start_in) rank_cnt_d[r] = '0;
    end
    for (int s = 0; s < NUM_SUITS; s++) begin
      suit_cnt_d[s] = suit_cnt_q[s];
      if (aligned.valid && aligned.is_suit && (aligned.pixel != suit_bits[s]))
        suit_cnt_d[s] = suit_cnt_q[s] + SUIT_W'(1);
      if (start_in) suit_cnt_d[s] = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      rank_addr_q <= '0;
      suit_addr_q <= '0;
      drain_q     <= '0;
      for (int i = 0; i < ROM_LATENCY; i++) pipe_q[i] <= '0;
      for (int r = 0; r < NUM_RANKS; r++) rank_cnt_q[r] <= '0;
      for (int s = 0; s < NUM_SUITS; s++) suit_cnt_q[s] <= '0;
    end else begin
      state_q     <= state_d;
      rank_addr_q <= rank_addr_d;
      suit_addr_q <= suit_addr_d;
      drain_q     <= drain_d;
      for (int i = 0; i < ROM_LATENCY; i++) pipe_q[i] <= pipe_d[i];
      for (int r = 0; r < NUM_RANKS; r++) rank_cnt_q[r] <= rank_cnt_d[r];
      for (int s = 0; s < NUM_SUITS; s++) suit_cnt_q[s] <= suit_cnt_d[s];
    end
  end

  for (genvar r = 0; r < NUM_RANKS; r++) begin : g_rank_out
    assign rank_scores_out[r*RANK_W +: RANK_W] = rank_cnt_q[r];
  end
  for (genvar s = 0; s < NUM_SUITS; s++) begin : g_suit_out
    assign suit_scores_out[s*SUIT_W +: SUIT_W] = suit_cnt_q[s];
  end

  assign busy_out         = (state_q != IDLE);
  assign scores_valid_out = (state_q == DONE);

`ifdef CORNER_SCORER_TRUNC_CHECK_EN
  logic error_q, error_d;

  // Flag an aborted pass; the flag drops with the next completed card.
  always_comb begin
    error_d = error_q;
    if (state_q == DONE) error_d = 1'b0;
    if (start_in && ((state_q == RANK) || (state_q == SUIT) || (state_q == DRAIN)))
      error_d = 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) error_q <= 1'b0;
    else        error_q <= error_d;
  end

  assign error_out = error_q && (state_q != DONE);
`else
  assign error_out = 1'b0;
`endif

endmodule

// File: tb/tb_corner_scorer.sv
// Directed self-checking bench for corner_scorer against the calibration template set.
`timescale 1ns/1ps
module tb_corner_scorer;
  import card_pkg::*;

  localparam int TOTAL = RANK_SIZE + SUIT_SIZE;

  logic clk_in = 1'b0;
  logic rst_in, start_in, pixel_in, pixel_valid_in;
  logic busy_out, scores_valid_out, error_out;
  logic [NUM_RANKS*RANK_W-1:0] rank_scores_out;
  logic [NUM_SUITS*SUIT_W-1:0] suit_scores_out;

  int tests_run = 0;
  int tests_failed = 0;
  int pulse_count = 0;
  bit img [TOTAL];
  int exp_rank [NUM_RANKS];
  int exp_suit [NUM_SUITS];
  logic exp_err;

  corner_scorer dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .start_in         (start_in),
    .pixel_in         (pixel_in),
    .pixel_valid_in   (pixel_valid_in),
    .busy_out         (busy_out),
    .rank_scores_out  (rank_scores_out),
    .suit_scores_out  (suit_scores_out),
    .scores_valid_out (scores_valid_out),
    .error_out        (error_out)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) if (scores_valid_out === 1'b1) pulse_count++;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Expected glyphs: rank two all ink; spade ink at suit pixels 288..299.
  function automatic bit tpl_rank(int r);
    return r == 0;
  endfunction

  function automatic bit tpl_suit(int s, int a);
    return (s == 3) && (a >= 288) && (a < 300);
  endfunction

  task automatic compute_expected();
    for (int r = 0; r < NUM_RANKS; r++) begin
      exp_rank[r] = 0;
      for (int a = 0; a < RANK_SIZE; a++) if (img[a] != tpl_rank(r)) exp_rank[r]++;
    end
    for (int s = 0; s < NUM_SUITS; s++) begin
      exp_suit[s] = 0;
      for (int a = 0; a < SUIT_SIZE; a++) if (img[RANK_SIZE+a] != tpl_suit(s, a)) exp_suit[s]++;
    end
  endtask

  task automatic pulse_start();
    start_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
  endtask

  task automatic feed(input int first, input int count, input int duty);
    for (int i = first; i < first + count; i++) begin
      while (duty < 100 && int'($urandom_range(99)) >= duty) begin
        pixel_valid_in = 1'b0;
        pixel_in = 1'($urandom);
        @(posedge clk_in); #1;
      end
      pixel_valid_in = 1'b1;
      pixel_in = img[i];
      @(posedge clk_in); #1;
    end
    pixel_valid_in = 1'b0;
    pixel_in = 1'b0;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 1;
    while (scores_valid_out !== 1'b1 && cycles < 50) begin
      @(posedge clk_in); #1;
      cycles++;
    end
    if (scores_valid_out !== 1'b1) cycles = -1;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; start_in = 1'b0; pixel_in = 1'b0; pixel_valid_in = 1'b0;
    repeat (2) @(posedge clk_in); #1;
    rst_in = 1'b0;
    @(posedge clk_in); #1;
    tests_run++;
    if (busy_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset busy: got %b expected 0", busy_out); end
    tests_run++;
    if (scores_valid_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset valid: got %b expected 0", scores_valid_out); end
    tests_run++;
    if (error_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset error: got %b expected 0", error_out); end
    tests_run++;
    if (rank_scores_out !== '0 || suit_scores_out !== '0) begin
      tests_failed++; $display("[TB] FAIL reset scores: got %h/%h expected 0", rank_scores_out, suit_scores_out);
    end
  endtask

  task automatic test_full_card(input string name, input int duty);
    int n, base;
    compute_expected();
    base = pulse_count;
    pulse_start();
    tests_run++;
    if (busy_out !== 1'b1) begin tests_failed++; $display("[TB] FAIL %s busy after start: got %b expected 1", name, busy_out); end
    feed(0, TOTAL, duty);
    wait_valid(n);
    tests_run++;
    if (n != ROM_LATENCY + 1) begin tests_failed++; $display("[TB] FAIL %s latency: got %0d expected %0d", name, n, ROM_LATENCY + 1); end
    for (int r = 0; r < NUM_RANKS; r++) begin
      tests_run++;
      if (rank_scores_out[r*RANK_W +: RANK_W] !== RANK_W'(exp_rank[r])) begin
        tests_failed++;
        $display("[TB] FAIL %s rank_score[%0d]: got %0d expected %0d", name, r, rank_scores_out[r*RANK_W +: RANK_W], exp_rank[r]);
      end
    end
    for (int s = 0; s < NUM_SUITS; s++) begin
      tests_run++;
      if (suit_scores_out[s*SUIT_W +: SUIT_W] !== SUIT_W'(exp_suit[s])) begin
        tests_failed++;
        $display("[TB] FAIL %s suit_score[%0d]: got %0d expected %0d", name, s, suit_scores_out[s*SUIT_W +: SUIT_W], exp_suit[s]);
      end
    end
    @(posedge clk_in); #1;
    tests_run++;
    if (scores_valid_out !== 1'b0 || busy_out !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL %s after pulse valid/busy: got %b/%b expected 0/0", name, scores_valid_out, busy_out);
    end
    tests_run++;
    if (pulse_count != base + 1) begin tests_failed++; $display("[TB] FAIL %s pulses: got %0d expected %0d", name, pulse_count - base, 1); end
    tests_run++;
    if (rank_scores_out[0 +: RANK_W] !== RANK_W'(exp_rank[0])) begin
      tests_failed++; $display("[TB] FAIL %s hold rank_score[0]: got %0d expected %0d", name, rank_scores_out[0 +: RANK_W], exp_rank[0]);
    end
  endtask

  task automatic test_all_zero();
    for (int i = 0; i < TOTAL; i++) img[i] = 1'b0;
    test_full_card("all_zero", 100);
  endtask

  task automatic test_all_one();
    for (int i = 0; i < TOTAL; i++) img[i] = 1'b1;
    test_full_card("all_one", 100);
  endtask

  task automatic test_random_duty();
    for (int i = 0; i < TOTAL; i++) img[i] = 1'($urandom);
    img[RANK_SIZE-1] = 1'b1;
    img[RANK_SIZE]   = 1'b1;
    test_full_card("random_duty30", 30);
  endtask

  task automatic test_restart();
    int n, base;
    for (int i = 0; i < TOTAL; i++) img[i] = 1'b1;
    base = pulse_count;
    pulse_start();
    tests_run++;
    if (error_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL restart error before abort: got %b expected 0", error_out); end
    feed(0, 500, 100);
    pulse_start();
    tests_run++;
    if (error_out !== exp_err) begin tests_failed++; $display("[TB] FAIL restart error after abort: got %b expected %b", error_out, exp_err); end
    for (int i = 0; i < TOTAL; i++) img[i] = (i % 3 == 0);
    compute_expected();
    feed(0, TOTAL, 100);
    tests_run++;
    if (error_out !== exp_err) begin tests_failed++; $display("[TB] FAIL restart error in drain: got %b expected %b", error_out, exp_err); end
    wait_valid(n);
    tests_run++;
    if (n != ROM_LATENCY + 1) begin tests_failed++; $display("[TB] FAIL restart latency: got %0d expected %0d", n, ROM_LATENCY + 1); end
    tests_run++;
    if (error_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL restart error at pulse: got %b expected 0", error_out); end
    for (int r = 0; r < NUM_RANKS; r++) begin
      tests_run++;
      if (rank_scores_out[r*RANK_W +: RANK_W] !== RANK_W'(exp_rank[r])) begin
        tests_failed++;
        $display("[TB] FAIL restart rank_score[%0d]: got %0d expected %0d", r, rank_scores_out[r*RANK_W +: RANK_W], exp_rank[r]);
      end
    end
    for (int s = 0; s < NUM_SUITS; s++) begin
      tests_run++;
      if (suit_scores_out[s*SUIT_W +: SUIT_W] !== SUIT_W'(exp_suit[s])) begin
        tests_failed++;
        $display("[TB] FAIL restart suit_score[%0d]: got %0d expected %0d", s, suit_scores_out[s*SUIT_W +: SUIT_W], exp_suit[s]);
      end
    end
    @(posedge clk_in); #1;
    tests_run++;
    if (pulse_count != base + 1) begin tests_failed++; $display("[TB] FAIL restart pulses: got %0d expected 1", pulse_count - base); end
    tests_run++;
    if (error_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL restart error after pulse: got %b expected 0", error_out); end
  endtask

  task automatic test_reset_mid_suit();
    int base;
    for (int i = 0; i < TOTAL; i++) img[i] = 1'b1;
    base = pulse_count;
    pulse_start();
    feed(0, RANK_SIZE + 100, 100);
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    tests_run++;
    if (busy_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_reset busy: got %b expected 0", busy_out); end
    tests_run++;
    if (rank_scores_out !== '0 || suit_scores_out !== '0) begin
      tests_failed++; $display("[TB] FAIL mid_reset scores: got %h/%h expected 0", rank_scores_out, suit_scores_out);
    end
    pixel_in = 1'b1;
    pixel_valid_in = 1'b1;
    repeat (10) begin @(posedge clk_in); #1; end
    pixel_valid_in = 1'b0;
    repeat (4) begin @(posedge clk_in); #1; end
    tests_run++;
    if (rank_scores_out !== '0 || suit_scores_out !== '0 || busy_out !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL idle_ignore scores/busy: got %h/%h/%b expected 0/0/0", rank_scores_out, suit_scores_out, busy_out);
    end
    tests_run++;
    if (pulse_count != base) begin tests_failed++; $display("[TB] FAIL mid_reset pulses: got %0d expected 0", pulse_count - base); end
  endtask

  task automatic test_back_to_back();
    int n, base;
    for (int i = 0; i < TOTAL; i++) img[i] = (i % 5 == 0);
    compute_expected();
    base = pulse_count;
    pulse_start();
    feed(0, TOTAL, 100);
    wait_valid(n);
    tests_run++;
    if (n != ROM_LATENCY + 1) begin tests_failed++; $display("[TB] FAIL b2b first latency: got %0d expected %0d", n, ROM_LATENCY + 1); end
    tests_run++;
    if (rank_scores_out[0 +: RANK_W] !== RANK_W'(exp_rank[0]) || suit_scores_out[3*SUIT_W +: SUIT_W] !== SUIT_W'(exp_suit[3])) begin
      tests_failed++; $display("[TB] FAIL b2b first scores rank0/spade: got %0d/%0d expected %0d/%0d",
        rank_scores_out[0 +: RANK_W], suit_scores_out[3*SUIT_W +: SUIT_W], exp_rank[0], exp_suit[3]);
    end
    pulse_start();
    tests_run++;
    if (scores_valid_out !== 1'b0 || busy_out !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL b2b restart valid/busy: got %b/%b expected 0/1", scores_valid_out, busy_out);
    end
    tests_run++;
    if (rank_scores_out !== '0 || suit_scores_out !== '0) begin
      tests_failed++; $display("[TB] FAIL b2b cleared scores: got %h/%h expected 0", rank_scores_out, suit_scores_out);
    end
    tests_run++;
    if (pulse_count != base + 1) begin tests_failed++; $display("[TB] FAIL b2b first pulses: got %0d expected 1", pulse_count - base); end
    for (int i = 0; i < TOTAL; i++) img[i] = (i % 7 == 1);
    compute_expected();
    feed(0, TOTAL, 100);
    wait_valid(n);
    tests_run++;
    if (n != ROM_LATENCY + 1) begin tests_failed++; $display("[TB] FAIL b2b second latency: got %0d expected %0d", n, ROM_LATENCY + 1); end
    for (int r = 0; r < NUM_RANKS; r++) begin
      tests_run++;
      if (rank_scores_out[r*RANK_W +: RANK_W] !== RANK_W'(exp_rank[r])) begin
        tests_failed++;
        $display("[TB] FAIL b2b rank_score[%0d]: got %0d expected %0d", r, rank_scores_out[r*RANK_W +: RANK_W], exp_rank[r]);
      end
    end
    for (int s = 0; s < NUM_SUITS; s++) begin
      tests_run++;
      if (suit_scores_out[s*SUIT_W +: SUIT_W] !== SUIT_W'(exp_suit[s])) begin
        tests_failed++;
        $display("[TB] FAIL b2b suit_score[%0d]: got %0d expected %0d", s, suit_scores_out[s*SUIT_W +: SUIT_W], exp_suit[s]);
      end
    end
    @(posedge clk_in); #1;
    tests_run++;
    if (pulse_count != base + 2) begin tests_failed++; $display("[TB] FAIL b2b total pulses: got %0d expected 2", pulse_count - base); end
  endtask

  initial begin
`ifdef CORNER_SCORER_TRUNC_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    void'($urandom(32'd2024));
    test_reset();
    test_all_zero();
    test_all_one();
    test_random_duty();
    test_restart();
    test_reset_mid_suit();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
